// File: rtl/dau_result_rx_pkg.sv
// dau_result_rx_pkg: shared DAU symbol codes and symbol class constants
package dau_result_rx_pkg;
  localparam int DAU_SYM_WIDTH = 5;
  typedef logic [DAU_SYM_WIDTH-1:0] dau_sym_t;
  localparam dau_sym_t SYM_PLUS    = 5'd10;
  localparam dau_sym_t SYM_MINUS   = 5'd11;
  localparam dau_sym_t SYM_MUL     = 5'd12;
  localparam dau_sym_t SYM_DIV     = 5'd13;
  localparam dau_sym_t SYM_RESULT  = 5'd14;
  localparam dau_sym_t SYM_RESET   = 5'd15;
  localparam dau_sym_t SYM_COMMA   = 5'd16;
  localparam dau_sym_t SYM_SEP     = 5'd17;
  localparam dau_sym_t SYM_INVALID = 5'd31;
  localparam int SYM_CLS_W = 3;
  typedef logic [SYM_CLS_W-1:0] sym_cls_t;
  localparam sym_cls_t SYM_CLS_DIGIT = 3'd0;
  localparam sym_cls_t SYM_CLS_MINUS = 3'd1;
  localparam sym_cls_t SYM_CLS_COMMA = 3'd2;
  localparam sym_cls_t SYM_CLS_SEP   = 3'd3;
  localparam sym_cls_t SYM_CLS_IDLE  = 3'd4;
  localparam sym_cls_t SYM_CLS_OTHER = 3'd5;
endpackage

// File: rtl/dau_sym_decode.sv
// dau_sym_decode: classify a DAU symbol and extract its digit value (0 for non-digits)
module dau_sym_decode
  import dau_result_rx_pkg::*;
(
  input  logic [DAU_SYM_WIDTH-1:0] i_symbol,
  output logic [SYM_CLS_W-1:0]     o_class,
  output logic [3:0]               o_digit
);
  logic is_digit;
  always_comb begin
    is_digit = i_symbol <= DAU_SYM_WIDTH'(9);
    o_digit  = is_digit ? i_symbol[3:0] : 4'd0;
    o_class  = is_digit                 ? SYM_CLS_DIGIT :
               i_symbol == SYM_MINUS    ? SYM_CLS_MINUS :
               i_symbol == SYM_COMMA    ? SYM_CLS_COMMA :
               i_symbol == SYM_SEP      ? SYM_CLS_SEP   :
               i_symbol == SYM_INVALID  ? SYM_CLS_IDLE  : SYM_CLS_OTHER;
  end
endmodule

// File: rtl/dau_result_rx.sv
// dau_result_rx: parse one DAU result frame into BCD and commit it to stable display outputs
module dau_result_rx
  import dau_result_rx_pkg::*;
#(
  parameter  int NUM_DIGITS = 10,
  localparam int CNT_W      = $clog2(NUM_DIGITS+1)
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [DAU_SYM_WIDTH-1:0] i_symbol,
  input  logic                     i_symbol_valid,
  input  logic                     i_clear,
  output logic [4*NUM_DIGITS-1:0]  o_digits,
  output logic                     o_neg,
  output logic [CNT_W-1:0]         o_num_digits,
  output logic [CNT_W-1:0]         o_frac_digits,
  output logic                     o_frame_valid,
  output logic                     o_frame_done,
  output logic                     o_error
);
  localparam logic [1:0] S_IDLE = 2'd0, S_INT = 2'd1, S_FRAC = 2'd2, S_DRAIN = 2'd3;
  logic [1:0] state, nxt;
  logic [SYM_CLS_W-1:0] cls;
  logic [3:0] dig;
  logic [4*NUM_DIGITS-1:0] w_digits;
  logic w_neg;
  logic [CNT_W-1:0] w_cnt, w_frac;
  logic act, full, shift, inc_frac, set_neg, commit, set_err;
  dau_sym_decode u_dec (.i_symbol(i_symbol), .o_class(cls), .o_digit(dig));
  always_comb begin
    nxt      = state;
    shift    = 1'b0;
    inc_frac = 1'b0;
    set_neg  = 1'b0;
    commit   = 1'b0;
    set_err  = 1'b0;
    act      = i_symbol_valid && cls != SYM_CLS_IDLE;
    full     = w_cnt == CNT_W'(NUM_DIGITS);
    if (act)
      case (state)
        S_IDLE: begin
          nxt     = (cls == SYM_CLS_DIGIT || cls == SYM_CLS_MINUS) ? S_INT :
                    cls == SYM_CLS_COMMA ? S_FRAC : S_IDLE;
          shift   = cls == SYM_CLS_DIGIT || cls == SYM_CLS_COMMA;
          set_neg = cls == SYM_CLS_MINUS;
        end
        S_INT, S_FRAC: begin
          if (cls == SYM_CLS_DIGIT) begin
            shift    = !full;
            inc_frac = !full && state == S_FRAC;
            nxt      = full ? S_DRAIN : state;
          end else if (cls == SYM_CLS_COMMA && state == S_INT) nxt = S_FRAC;
          else if (cls == SYM_CLS_SEP) begin
            commit  = w_cnt != '0;
            set_err = w_cnt == '0;
            nxt     = S_IDLE;
          end else nxt = S_DRAIN;
          set_err = set_err || nxt == S_DRAIN;
        end
        default: nxt = cls == SYM_CLS_SEP ? S_IDLE : S_DRAIN;
      endcase
  end
  // A comma in S_IDLE shifts the decoder's 0 digit value, giving the implicit leading zero
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state         <= S_IDLE;
      w_digits      <= '0;
      w_neg         <= 1'b0;
      w_cnt         <= '0;
      w_frac        <= '0;
      o_digits      <= '0;
      o_neg         <= 1'b0;
      o_num_digits  <= '0;
      o_frac_digits <= '0;
      o_frame_valid <= 1'b0;
      o_frame_done  <= 1'b0;
      o_error       <= 1'b0;
    end else if (i_clear) begin
      state         <= S_IDLE;
      w_digits      <= '0;
      w_neg         <= 1'b0;
      w_cnt         <= '0;
      w_frac        <= '0;
      o_digits      <= '0;
      o_neg         <= 1'b0;
      o_num_digits  <= '0;
      o_frac_digits <= '0;
      o_frame_valid <= 1'b0;
      o_frame_done  <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      state        <= nxt;
      o_frame_done <= commit;
      if (nxt == S_IDLE) begin
        w_digits <= '0;
        w_neg    <= 1'b0;
        w_cnt    <= '0;
        w_frac   <= '0;
      end else begin
        if (shift) begin
          w_digits <= {w_digits[4*NUM_DIGITS-5:0], dig};
          w_cnt    <= w_cnt + 1'b1;
        end
        if (inc_frac) w_frac <= w_frac + 1'b1;
        if (set_neg) w_neg <= 1'b1;
      end
      if (commit) begin
        o_digits      <= w_digits;
        o_neg         <= w_neg;
        o_num_digits  <= w_cnt;
        o_frac_digits <= w_frac;
        o_frame_valid <= 1'b1;
        o_error       <= 1'b0;
      end else if (set_err) o_error <= 1'b1;
    end
endmodule
